// File: rtl/audio_sfx_pkg.sv
// Shared types and helpers for the sound-effect scheduler.
package audio_sfx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PLAY = 2'd2
    } sfx_state_e;

    localparam int unsigned LOAD_CYCLES       = 2;
    localparam int unsigned MAX_SFX           = 32;
    localparam logic signed [31:0] DEFAULT_AMPLITUDE = 32'sd100000000;

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic int unsigned lowest_set(input logic [MAX_SFX-1:0] v);
        int unsigned idx;
        idx = 0;
        for (int i = MAX_SFX - 1; i >= 0; i--) begin
            if (v[i]) idx = unsigned'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/audio_sfx_scheduler_if.sv
// Request, tone-ROM and Audio_Controller signals of the scheduler.
interface audio_sfx_scheduler_if #(
    parameter int unsigned NUM_SFX = 4,
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned DELAY_W = 19
);
    localparam int unsigned ID_W = (NUM_SFX > 1) ? $clog2(NUM_SFX) : 1;

    logic [NUM_SFX-1:0]        sfx_req;
    logic [NUM_SFX*ADDR_W-1:0] sfx_base;
    logic [NUM_SFX*ADDR_W-1:0] sfx_len;
    logic                      stop;
    logic [ADDR_W-1:0]         rom_addr;
    logic [DELAY_W-1:0]        rom_delay;
    logic                      audio_out_allowed;
    logic signed [31:0]        sample_out;
    logic                      write_audio_out;
    logic                      busy;
    logic [ID_W-1:0]           active_id;
    logic                      done;

    // Scheduler side
    modport master (
        input  sfx_req, sfx_base, sfx_len, stop, rom_delay, audio_out_allowed,
        output rom_addr, sample_out, write_audio_out, busy, active_id, done
    );

    // Game logic, ROM and Audio_Controller side
    modport slave (
        output sfx_req, sfx_base, sfx_len, stop, rom_delay, audio_out_allowed,
        input  rom_addr, sample_out, write_audio_out, busy, active_id, done
    );
endinterface

// File: rtl/sfx_tone_gen.sv
// Square-wave generator: half-period counter, polarity bit and registered sample.
module sfx_tone_gen
    import audio_sfx_pkg::*;
#(
    parameter int unsigned        DELAY_W   = 19,
    parameter logic signed [31:0] AMPLITUDE = DEFAULT_AMPLITUDE
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               clear,
    input  logic               enable,
    input  logic [DELAY_W-1:0] note_delay,
    output logic signed [31:0] sample
);

    logic [DELAY_W-1:0] phase_cnt_q, phase_cnt_d;
    logic               snd_q, snd_d;
    logic signed [31:0] sample_q, sample_d;

    // enable reflects the upcoming state, so the sample lines up with the scheduler state
    always_comb begin
        phase_cnt_d = phase_cnt_q;
        snd_d       = snd_q;
        if (clear) begin
            phase_cnt_d = '0;
            snd_d       = 1'b0;
        end else if (enable) begin
            if (note_delay == '0) begin
                phase_cnt_d = '0;
                snd_d       = 1'b0;
            end else if (phase_cnt_q == note_delay) begin
                phase_cnt_d = '0;
                snd_d       = ~snd_q;
            end else begin
                phase_cnt_d = phase_cnt_q + 1'b1;
            end
        end
        if (enable && (note_delay != '0)) begin
            sample_d = snd_d ? AMPLITUDE : -AMPLITUDE;
        end else begin
            sample_d = '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            phase_cnt_q <= '0;
            snd_q       <= 1'b0;
            sample_q    <= '0;
        end else begin
            phase_cnt_q <= phase_cnt_d;
            snd_q       <= snd_d;
            sample_q    <= sample_d;
        end
    end

    assign sample = sample_q;

endmodule

// File: rtl/audio_sfx_scheduler.sv
// Fixed-priority, preemptive scheduler that plays note-ROM clips one beat per note
// and feeds the Audio_Controller a square-wave sample stream.
module audio_sfx_scheduler
    import audio_sfx_pkg::*;
#(
    parameter int unsigned        NUM_SFX    = 4,
    parameter int unsigned        ADDR_W     = 10,
    parameter int unsigned        DELAY_W    = 19,
    parameter int unsigned        BEAT_TICKS = 2500000,
    parameter logic signed [31:0] AMPLITUDE  = DEFAULT_AMPLITUDE
) (
    input  logic                  CLOCK_50,
    input  logic                  resetn,
    audio_sfx_scheduler_if.master bus
);

    localparam int unsigned ID_W   = (NUM_SFX > 1) ? $clog2(NUM_SFX) : 1;
    localparam int unsigned BEAT_W = (BEAT_TICKS > 1) ? $clog2(BEAT_TICKS) : 1;
    localparam int unsigned LOAD_W = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;

    sfx_state_e         state_q, state_d;
    logic [NUM_SFX-1:0] pending_q, pending_d;
    logic [ID_W-1:0]    active_id_q, active_id_d;
    logic [ADDR_W-1:0]  note_idx_q, note_idx_d;
    logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
    logic [LOAD_W-1:0]  load_cnt_q, load_cnt_d;
    logic [BEAT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [DELAY_W-1:0] note_delay_q, note_delay_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               grant_any;
    logic [ID_W-1:0]    grant_id;
    logic [ADDR_W-1:0]  grant_len;
    logic [ADDR_W-1:0]  active_len;
    logic               preempt;
    logic               do_grant;
    logic               tone_clear;
    logic               tone_enable;

    // Arbitration over already-latched requests only
    always_comb begin
        grant_any  = |pending_q;
        grant_id   = ID_W'(lowest_set(MAX_SFX'(pending_q)));
        grant_len  = bus.sfx_len[grant_id*ADDR_W +: ADDR_W];
        active_len = bus.sfx_len[active_id_q*ADDR_W +: ADDR_W];
        preempt    = grant_any && (grant_id < active_id_q);
    end

    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q | bus.sfx_req;
        active_id_d  = active_id_q;
        note_idx_d   = note_idx_q;
        rom_addr_d   = rom_addr_q;
        load_cnt_d   = load_cnt_q;
        beat_cnt_d   = beat_cnt_q;
        note_delay_d = note_delay_q;
        done_d       = 1'b0;
        do_grant     = 1'b0;
        tone_clear   = 1'b0;

        if (bus.stop) begin
            state_d   = ST_IDLE;
            pending_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: do_grant = grant_any;
                ST_LOAD: begin
                    if (preempt) begin
                        do_grant = 1'b1;
                    end else if (load_cnt_q == LOAD_W'(LOAD_CYCLES - 1)) begin
                        state_d      = ST_PLAY;
                        note_delay_d = bus.rom_delay;
                        beat_cnt_d   = '0;
                        tone_clear   = 1'b1;
                    end else begin
                        load_cnt_d = load_cnt_q + 1'b1;
                    end
                end
                ST_PLAY: begin
                    if (preempt) begin
                        do_grant = 1'b1;
                    end else if (beat_cnt_q == BEAT_W'(BEAT_TICKS - 1)) begin
                        if ((note_idx_q + 1'b1) == active_len) begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            note_idx_d = note_idx_q + 1'b1;
                            rom_addr_d = rom_addr_q + 1'b1;
                            load_cnt_d = '0;
                            state_d    = ST_LOAD;
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            // A grant drops whatever was playing; empty clips finish on the spot
            if (do_grant) begin
                pending_d[grant_id] = 1'b0;
                active_id_d         = grant_id;
                note_idx_d          = '0;
                load_cnt_d          = '0;
                if (grant_len == '0) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    rom_addr_d = bus.sfx_base[grant_id*ADDR_W +: ADDR_W];
                    state_d    = ST_LOAD;
                end
            end
        end

        busy_d      = (state_d != ST_IDLE);
        tone_enable = (state_d == ST_PLAY);
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            pending_q    <= '0;
            active_id_q  <= '0;
            note_idx_q   <= '0;
            rom_addr_q   <= '0;
            load_cnt_q   <= '0;
            beat_cnt_q   <= '0;
            note_delay_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            active_id_q  <= active_id_d;
            note_idx_q   <= note_idx_d;
            rom_addr_q   <= rom_addr_d;
            load_cnt_q   <= load_cnt_d;
            beat_cnt_q   <= beat_cnt_d;
            note_delay_q <= note_delay_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    sfx_tone_gen #(
        .DELAY_W  (DELAY_W),
        .AMPLITUDE(AMPLITUDE)
    ) u_tone (
        .clk       (CLOCK_50),
        .resetn    (resetn),
        .clear     (tone_clear),
        .enable    (tone_enable),
        .note_delay(note_delay_d),
        .sample    (bus.sample_out)
    );

    // The FIFO is kept fed with silence as well as tones
    assign bus.write_audio_out = bus.audio_out_allowed;
    assign bus.rom_addr        = rom_addr_q;
    assign bus.busy            = busy_q;
    assign bus.active_id       = active_id_q;
    assign bus.done            = done_q;

endmodule

// File: tb/tb_audio_sfx_scheduler.sv
// Bench for audio_sfx_scheduler: vector table, directed corner sequences and
// random traffic against a clip-level reference model.
module tb_audio_sfx_scheduler;

    localparam int unsigned NUM_SFX = 4;
    localparam int unsigned ADDR_W  = 10;
    localparam int unsigned DELAY_W = 19;
    localparam int          BT      = 8;
    localparam int          AMP     = 100000000;
    localparam int          M_IDLE  = 0;
    localparam int          M_LOAD  = 1;
    localparam int          M_PLAY  = 2;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    audio_sfx_scheduler_if #(.NUM_SFX(NUM_SFX), .ADDR_W(ADDR_W), .DELAY_W(DELAY_W)) bus ();

    audio_sfx_scheduler #(
        .NUM_SFX   (NUM_SFX),
        .ADDR_W    (ADDR_W),
        .DELAY_W   (DELAY_W),
        .BEAT_TICKS(BT),
        .AMPLITUDE (32'sd100000000)
    ) dut (
        .CLOCK_50(clk),
        .resetn  (resetn),
        .bus     (bus)
    );

    // Synchronous tone ROM: q follows the address one clock later
    logic [DELAY_W-1:0] rom [1024];
    always_ff @(posedge clk) bus.rom_delay <= rom[bus.rom_addr];

    int base_a [4] = '{0, 16, 40, 1022};
    int len_a  [4] = '{0, 3, 2, 5};

    int errors = 0;
    int checks = 0;
    int done_seen = 0;
    int busy_seen = 0;
    logic cur_allow;

    // Reference model state: mode, pending set, clip position
    int m_mode, m_id, m_idx, m_addr, m_lcnt, m_beat, m_nd;
    logic [3:0] m_pend;
    logic m_done;

    typedef struct {
        logic [3:0] req;
        logic       allow;
        int         busy;
        int         done;
        int         id;
        int         addr;
        int         smp;
    } vec_t;
    vec_t tbl [11];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_pend = '0; m_id = 0; m_idx = 0;
        m_addr = 0; m_lcnt = 0; m_beat = 0; m_nd = 0; m_done = 1'b0;
    endtask

    task automatic model_edge(input logic [3:0] req, input logic stp);
        logic [3:0] newp;
        int g;
        m_done = 1'b0;
        if (stp) begin
            m_mode = M_IDLE;
            m_pend = '0;
            return;
        end
        newp = m_pend | req;
        g = -1;
        for (int i = 3; i >= 0; i--) if (m_pend[i]) g = i;
        if (g >= 0 && (m_mode == M_IDLE || g < m_id)) begin
            newp[g] = 1'b0;
            m_id = g;
            m_idx = 0;
            if (len_a[g] == 0) begin
                m_done = 1'b1;
                m_mode = M_IDLE;
            end else begin
                m_addr = base_a[g];
                m_mode = M_LOAD;
                m_lcnt = 0;
            end
        end else if (m_mode == M_LOAD) begin
            m_lcnt++;
            if (m_lcnt == 2) begin
                m_mode = M_PLAY;
                m_beat = 0;
                m_nd = int'(rom[10'(m_addr)]);
            end
        end else if (m_mode == M_PLAY) begin
            m_beat++;
            if (m_beat == BT) begin
                if (m_idx + 1 == len_a[m_id]) begin
                    m_done = 1'b1;
                    m_mode = M_IDLE;
                end else begin
                    m_idx++;
                    m_addr = (m_addr + 1) % 1024;
                    m_mode = M_LOAD;
                    m_lcnt = 0;
                end
            end
        end
        m_pend = newp;
    endtask

    function automatic int model_sample();
        if (m_mode != M_PLAY || m_nd == 0) return 0;
        return (((m_beat / (m_nd + 1)) % 2) != 0) ? AMP : -AMP;
    endfunction

    task automatic check_model();
        chk("busy", int'(bus.busy), int'(m_mode != M_IDLE));
        chk("done", int'(bus.done), int'(m_done));
        chk("active_id", int'(bus.active_id), m_id);
        chk("rom_addr", int'(bus.rom_addr), m_addr);
        chk("sample_out", int'(bus.sample_out), model_sample());
        chk("write_audio_out", int'(bus.write_audio_out), int'(cur_allow));
    endtask

    task automatic step(input logic [3:0] req, input logic stp, input logic allow);
        bus.sfx_req = req;
        bus.stop = stp;
        bus.audio_out_allowed = allow;
        cur_allow = allow;
        @(posedge clk);
        model_edge(req, stp);
        #1;
        bus.sfx_req = '0;
        bus.stop = 1'b0;
        check_model();
        if (bus.done) done_seen++;
        if (bus.busy) busy_seen++;
    endtask

    initial begin
        int d0, b0;
        logic [3:0] r;
        logic s;

        for (int i = 0; i < 1024; i++) rom[i] = '0;
        rom[16] = 19'd3;  rom[17] = 19'd0; rom[18] = 19'd5;
        rom[40] = 19'd2;  rom[41] = 19'd1;
        rom[1022] = 19'd4; rom[1023] = 19'd0; rom[0] = 19'd7; rom[1] = 19'd1; rom[2] = 19'd2;
        for (int g = 0; g < 4; g++) begin
            bus.sfx_base[g*ADDR_W +: ADDR_W] = 10'(base_a[g]);
            bus.sfx_len[g*ADDR_W +: ADDR_W]  = 10'(len_a[g]);
        end

        //            req      allow busy done id addr smp
        tbl[0]  = '{4'b0001, 1'b1, 0, 0, 0, 0,  0};
        tbl[1]  = '{4'b0000, 1'b0, 0, 1, 0, 0,  0};
        tbl[2]  = '{4'b0000, 1'b1, 0, 0, 0, 0,  0};
        tbl[3]  = '{4'b0010, 1'b1, 0, 0, 0, 0,  0};
        tbl[4]  = '{4'b0000, 1'b0, 1, 0, 1, 16, 0};
        tbl[5]  = '{4'b0000, 1'b1, 1, 0, 1, 16, 0};
        tbl[6]  = '{4'b0000, 1'b1, 1, 0, 1, 16, -1};
        tbl[7]  = '{4'b0000, 1'b0, 1, 0, 1, 16, -1};
        tbl[8]  = '{4'b0000, 1'b1, 1, 0, 1, 16, -1};
        tbl[9]  = '{4'b0000, 1'b1, 1, 0, 1, 16, -1};
        tbl[10] = '{4'b0000, 1'b1, 1, 0, 1, 16, 1};

        bus.sfx_req = '0;
        bus.stop = 1'b0;
        bus.audio_out_allowed = 1'b1;
        cur_allow = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_model();
        bus.audio_out_allowed = 1'b0;
        cur_allow = 1'b0;
        #1;
        chk("reset_write_follows", int'(bus.write_audio_out), 0);
        @(negedge clk);
        resetn = 1'b1;

        // Empty clip on bit 0, then first notes of clip 1
        for (int i = 0; i < 11; i++) begin
            step(tbl[i].req, 1'b0, tbl[i].allow);
            chk("tbl_busy", int'(bus.busy), tbl[i].busy);
            chk("tbl_done", int'(bus.done), tbl[i].done);
            chk("tbl_active_id", int'(bus.active_id), tbl[i].id);
            chk("tbl_rom_addr", int'(bus.rom_addr), tbl[i].addr);
            chk("tbl_sample", int'(bus.sample_out), tbl[i].smp * AMP);
        end

        d0 = done_seen;
        repeat (40) step(4'b0000, 1'b0, 1'($urandom));
        chk("clip1_done_count", done_seen - d0, 1);
        chk("clip1_idle", int'(bus.busy), 0);

        // Preempt a 5-note bit-3 clip with bit 2
        d0 = done_seen;
        step(4'b1000, 1'b0, 1'b1);
        repeat (14) step(4'b0000, 1'b0, 1'b1);
        chk("pre_active_id", int'(bus.active_id), 3);
        step(4'b0100, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b1);
        chk("preempt_id", int'(bus.active_id), 2);
        chk("preempt_addr", int'(bus.rom_addr), 40);
        chk("preempt_busy", int'(bus.busy), 1);
        chk("preempt_no_done", done_seen - d0, 0);
        repeat (30) step(4'b0000, 1'b0, 1'b1);
        chk("preempt_clip2_done", done_seen - d0, 1);
        chk("preempt_not_resumed", int'(bus.busy), 0);

        // Two requests in one cycle play back to back
        d0 = done_seen;
        step(4'b1010, 1'b0, 1'b1);
        repeat (100) step(4'b0000, 1'b0, 1'($urandom));
        chk("dual_done_count", done_seen - d0, 2);
        chk("dual_idle", int'(bus.busy), 0);

        // Stop mid-play with bit 3 pending; a same-cycle request is discarded
        d0 = done_seen;
        step(4'b0010, 1'b0, 1'b1);
        repeat (8) step(4'b0000, 1'b0, 1'b1);
        step(4'b1000, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b1);
        chk("stop_pre_busy", int'(bus.busy), 1);
        step(4'b0100, 1'b1, 1'b0);
        chk("stop_busy", int'(bus.busy), 0);
        chk("stop_sample", int'(bus.sample_out), 0);
        chk("stop_write", int'(bus.write_audio_out), 0);
        b0 = busy_seen;
        repeat (20) step(4'b0000, 1'b0, 1'($urandom));
        chk("stop_flushed", busy_seen - b0, 0);
        chk("stop_no_done", done_seen - d0, 0);

        // Asynchronous reset between edges in the middle of a note
        step(4'b0010, 1'b0, 1'b1);
        repeat (10) step(4'b0000, 1'b0, 1'b1);
        chk("rst_pre_busy", int'(bus.busy), 1);
        #3;
        resetn = 1'b0;
        #1;
        model_reset();
        check_model();
        @(posedge clk);
        #1;
        check_model();
        #2;
        resetn = 1'b1;
        b0 = busy_seen;
        repeat (15) step(4'b0000, 1'b0, 1'b1);
        chk("rst_no_playback", busy_seen - b0, 0);

        // Random traffic against the reference model
        repeat (2500) begin
            r = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'b0000;
            s = ($urandom_range(0, 299) == 0);
            step(r, s, 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
